// File: rtl/l_class_oc_echo_drain.sv
// -----------------------------------------------------------------------------
// l_class_oc_echo_drain
//
// Pulls one 32-bit message at a time from an upstream Fifo and holds it for a
// programmable number of cycles. It then echoes the message on the "heard"
// indication and counts every delivered message. Only one message is ever in
// flight, and the FSM steps IDLE -> (WAIT) -> SEND -> IDLE.
//
// Parameters
//   DELAY_INIT     8-bit delay value loaded into the delay register at reset.
//
// Ports
//   CLK            rising-edge clock for all state
//   nRST           asynchronous active-low reset
//   first          head value of the upstream Fifo
//   first__RDY     upstream head valid
//   deq__ENA       dequeue strobe to the upstream Fifo (combinational, IDLE only)
//   deq__RDY       upstream dequeue permitted
//   heard__ENA     indication strobe, one message per asserted cycle
//   heard_v        indication payload (always the captured data register)
//   heard__RDY     indication sink ready
//   setDelay__ENA  load a new delay
//   setDelay_v     new delay value in cycles
//   setDelay__RDY  setDelay accepted when high (IDLE only)
//   count          number of messages delivered on heard (wraps at 2^16)
//   count__RDY     count valid, tied high
// -----------------------------------------------------------------------------
module l_class_oc_echo_drain #(
    parameter logic [7:0] DELAY_INIT = 8'd0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] first,
    input  logic        first__RDY,
    output logic        deq__ENA,
    input  logic        deq__RDY,
    output logic        heard__ENA,
    output logic [31:0] heard_v,
    input  logic        heard__RDY,
    input  logic        setDelay__ENA,
    input  logic [7:0]  setDelay_v,
    output logic        setDelay__RDY,
    output logic [15:0] count,
    output logic        count__RDY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] data_r;
    logic [31:0] data_nxt_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_nxt_s;
    logic [7:0]  delay_r;
    logic [7:0]  delay_nxt_s;
    logic [15:0] count_r;
    logic [15:0] count_nxt_s;
    logic [7:0]  eff_delay_s;
    logic        deq_s;
    logic        heard_s;
    logic        set_rdy_s;
    logic        set_acc_s;

    // State, data, down-counter, delay and delivery-count registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
            data_r  <= 32'd0;
            cnt_r   <= 8'd0;
            delay_r <= DELAY_INIT;
            count_r <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            data_r  <= data_nxt_s;
            cnt_r   <= cnt_nxt_s;
            delay_r <= delay_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Next-state and method-enable decode for the single-message FSM.
    always_comb begin
        state_nxt_s = state_r;
        data_nxt_s  = data_r;
        cnt_nxt_s   = cnt_r;
        delay_nxt_s = delay_r;
        count_nxt_s = count_r;
        eff_delay_s = delay_r;
        deq_s       = 1'b0;
        heard_s     = 1'b0;
        set_rdy_s   = 1'b0;
        set_acc_s   = 1'b0;

        case (state_r)
            IDLE: begin
                set_rdy_s = 1'b1;
                set_acc_s = setDelay__ENA && set_rdy_s;
                deq_s     = first__RDY && deq__RDY;
                // A delay written in the same cycle as a dequeue applies to
                // that very message, so bypass the stored register.
                if (set_acc_s) begin
                    delay_nxt_s = setDelay_v;
                    eff_delay_s = setDelay_v;
                end else begin
                    eff_delay_s = delay_r;
                end
                if (deq_s) begin
                    data_nxt_s = first;
                    cnt_nxt_s  = eff_delay_s;
                    if (eff_delay_s == 8'd0) begin
                        state_nxt_s = SEND;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                // Leaving on count 1 yields exactly D cycles in WAIT; count 0
                // is unreachable here but is treated as "done" rather than
                // wrapping to 255.
                if (cnt_r <= 8'd1) begin
                    cnt_nxt_s   = 8'd0;
                    state_nxt_s = SEND;
                end else begin
                    cnt_nxt_s   = cnt_r - 8'd1;
                    state_nxt_s = WAIT;
                end
            end
            SEND: begin
                heard_s = heard__RDY;
                if (heard__RDY) begin
                    count_nxt_s = count_r + 16'd1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 8'd0;
            end
        endcase
    end

    // Dequeue is suppressed while reset is asserted, even though the state
    // register already reads IDLE.
    assign deq__ENA      = deq_s && nRST;
    assign heard__ENA    = heard_s;
    assign heard_v       = data_r;
    assign setDelay__RDY = set_rdy_s;
    assign count         = count_r;
    assign count__RDY    = 1'b1;

endmodule
